// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - shared states, error codes, timing constants and checksum helper for dht_reader
package dht_pkg;

    localparam int FRAME_BITS         = 40;
    localparam int DHT11_START_LOW_US = 19000;
    localparam int DHT22_START_LOW_US = 1100;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_NO_RESP  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_CHECKSUM = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_RELEASE,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_CHECK,
        ST_FAIL,
        ST_COOLDOWN
    } state_t;

    // Host start-low duration in microseconds for the selected sensor family.
    function automatic int start_low_us(input int sensor_type);
        return (sensor_type == 1) ? DHT22_START_LOW_US : DHT11_START_LOW_US;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Last byte must equal the 8-bit wrapping sum of the four data bytes.
    function automatic logic checksum_ok(input logic [FRAME_BITS-1:0] frame);
        logic [7:0] sum;
        sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return sum == frame[7:0];
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - free-running one-cycle tick every microsecond
module us_tick_gen #(
    parameter int CLK_FREQ_HZ = 50000000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int DIV = CLK_FREQ_HZ / 1000000;
    localparam int CW  = $clog2(DIV);

    logic [CW-1:0] count;

    // Divide the system clock down to a 1 us strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == CW'(DIV - 1)) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/dht_reader.sv
// rtl/dht_reader.sv - single-wire DHT11/DHT22 reader with timeouts, checksum and read cooldown
module dht_reader
    import dht_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 50000000,
    parameter int SENSOR_TYPE      = 0,
    parameter int BIT_THRESHOLD_US = 40,
    parameter int TIMEOUT_US       = 100,
    parameter int MIN_INTERVAL_MS  = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    inout  wire                   dht_io,
    output logic [FRAME_BITS-1:0] data_out,
    output logic                  done,
    output logic                  busy,
    output logic                  error,
    output logic [1:0]            error_code
);

    localparam int START_LOW_US = start_low_us(SENSOR_TYPE);
    localparam int COOLDOWN_US  = MIN_INTERVAL_MS * 1000;
    localparam int MAX_COUNT    = max_int(max_int(START_LOW_US, COOLDOWN_US),
                                          max_int(TIMEOUT_US, BIT_THRESHOLD_US));
    localparam int CNT_W        = $clog2(MAX_COUNT + 1);
    localparam int IDX_W        = $clog2(FRAME_BITS + 1);

    state_t                  state;
    state_t                  next_state;
    logic                    tick;
    logic [1:0]              sync_ff;
    logic                    line_prev;
    logic                    sync_line;
    logic                    rise;
    logic                    fall;
    logic [CNT_W-1:0]        us_count;
    logic                    timeout;
    logic [IDX_W-1:0]        bit_index;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [1:0]              fail_code;
    logic [1:0]              fail_code_q;
    logic                    drive_low;

    us_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    // Open-drain pin: only ever pull low; the external pull-up provides the high level.
    assign dht_io = drive_low ? 1'b0 : 1'bz;

    assign sync_line = sync_ff[1];
    assign rise      = sync_line & ~line_prev;
    assign fall      = ~sync_line & line_prev;
    assign timeout   = (us_count >= CNT_W'(TIMEOUT_US));

    // Two-flop synchroniser plus previous-value register for edge detection; idle line is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_ff   <= 2'b11;
            line_prev <= 1'b1;
        end else begin
            sync_ff   <= {sync_ff[0], dht_io};
            line_prev <= sync_line;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; line edges win over a timeout landing in the same cycle.
    always_comb begin
        next_state = state;
        fail_code  = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (start && sync_line) next_state = ST_START_LOW;
            end
            ST_START_LOW: begin
                if (us_count >= CNT_W'(START_LOW_US)) next_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (fall) begin
                    next_state = ST_RESP_LOW;
                end else if (timeout) begin
                    next_state = ST_FAIL;
                    fail_code  = ERR_NO_RESP;
                end
            end
            ST_RESP_LOW: begin
                if (rise) begin
                    next_state = ST_RESP_HIGH;
                end else if (timeout) begin
                    next_state = ST_FAIL;
                    fail_code  = ERR_NO_RESP;
                end
            end
            ST_RESP_HIGH: begin
                if (fall) begin
                    next_state = ST_BIT_LOW;
                end else if (timeout) begin
                    next_state = ST_FAIL;
                    fail_code  = ERR_NO_RESP;
                end
            end
            ST_BIT_LOW: begin
                if (rise) begin
                    next_state = ST_BIT_HIGH;
                end else if (timeout) begin
                    next_state = ST_FAIL;
                    fail_code  = ERR_TIMEOUT;
                end
            end
            ST_BIT_HIGH: begin
                if (fall) begin
                    next_state = (bit_index == IDX_W'(FRAME_BITS - 1)) ? ST_CHECK : ST_BIT_LOW;
                end else if (timeout) begin
                    next_state = ST_FAIL;
                    fail_code  = ERR_TIMEOUT;
                end
            end
            ST_CHECK:    next_state = ST_COOLDOWN;
            ST_FAIL:     next_state = ST_COOLDOWN;
            ST_COOLDOWN: begin
                if (us_count >= CNT_W'(COOLDOWN_US)) next_state = ST_IDLE;
            end
            default:     next_state = ST_IDLE;
        endcase
    end

    // Phase timer in microseconds, restarted on every state change and parked at zero in IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            us_count <= '0;
        end else if (next_state != state || state == ST_IDLE) begin
            us_count <= '0;
        end else if (tick) begin
            us_count <= us_count + 1'b1;
        end
    end

    // Frame capture: high-time above threshold is a '1'; a new frame starts clean after the response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_index   <= '0;
            fail_code_q <= ERR_NONE;
        end else begin
            if (state == ST_RESP_HIGH && fall) begin
                shift_reg <= '0;
                bit_index <= '0;
            end else if (state == ST_BIT_HIGH && fall) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], (us_count > CNT_W'(BIT_THRESHOLD_US))};
                bit_index <= bit_index + 1'b1;
            end
            if (next_state == ST_FAIL && state != ST_FAIL) begin
                fail_code_q <= fail_code;
            end
        end
    end

    // Registered pin drive and busy flag, both following the upcoming state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drive_low <= 1'b0;
            busy      <= 1'b0;
        end else begin
            drive_low <= (next_state == ST_START_LOW);
            busy      <= (next_state != ST_IDLE);
        end
    end

    // Transaction results: done pulse, error level and code, last good frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done       <= 1'b0;
            error      <= 1'b0;
            error_code <= ERR_NONE;
            data_out   <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE && next_state == ST_START_LOW) begin
                error      <= 1'b0;
                error_code <= ERR_NONE;
            end else if (state == ST_CHECK) begin
                done <= 1'b1;
                if (checksum_ok(shift_reg)) begin
                    data_out   <= shift_reg;
                    error      <= 1'b0;
                    error_code <= ERR_NONE;
                end else begin
                    error      <= 1'b1;
                    error_code <= ERR_CHECKSUM;
                end
            end else if (state == ST_FAIL) begin
                done       <= 1'b1;
                error      <= 1'b1;
                error_code <= fail_code_q;
            end
        end
    end

endmodule

// File: tb/tb_dht_reader.sv
// tb/tb_dht_reader.sv - randomized self-checking bench for dht_reader with a sensor model
`timescale 1ns/1ps
module tb_dht_reader;

    localparam int CLK_FREQ_HZ      = 2000000;
    localparam int SENSOR_TYPE      = 1;
    localparam int BIT_THRESHOLD_US = 40;
    localparam int TIMEOUT_US       = 100;
    localparam int MIN_INTERVAL_MS  = 1;
    localparam int MODE_FRAME = 0;
    localparam int MODE_NONE  = 1;
    localparam int MODE_ABORT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sensor_low = 1'b0;
    wire         dht_io;
    logic [39:0] data_out;
    logic        done;
    logic        busy;
    logic        error;
    logic [1:0]  error_code;

    int          n_checks = 0;
    int          n_errors = 0;
    int          txn_issued = 0;
    int          done_count = 0;
    int          exp_mode = MODE_FRAME;
    logic [39:0] exp_frame = '0;
    logic [39:0] model_data = '0;
    logic        model_error = 1'b0;
    logic [1:0]  model_code = 2'b00;
    time         last_fall = 0;
    time         t_done = 0;

    assign dht_io = sensor_low ? 1'b0 : 1'bz;
    pullup (dht_io);

    dht_reader #(
        .CLK_FREQ_HZ     (CLK_FREQ_HZ),
        .SENSOR_TYPE     (SENSOR_TYPE),
        .BIT_THRESHOLD_US(BIT_THRESHOLD_US),
        .TIMEOUT_US      (TIMEOUT_US),
        .MIN_INTERVAL_MS (MIN_INTERVAL_MS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dht_io    (dht_io),
        .data_out  (data_out),
        .done      (done),
        .busy      (busy),
        .error     (error),
        .error_code(error_code)
    );

    always #250 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [1:0] expected_code(input int mode, input logic [39:0] f);
        int sum;
        if (mode == MODE_NONE) return 2'b01;
        if (mode == MODE_ABORT) return 2'b10;
        sum = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
        return (sum == int'(f[7:0])) ? 2'b00 : 2'b11;
    endfunction

    task automatic compare_loop();
        logic [1:0] code;
        forever begin
            @(negedge clock);
            if (reset) begin
                model_data  = '0;
                model_error = 1'b0;
                model_code  = 2'b00;
            end else begin
                if (dht_io === 1'b0 && !sensor_low) begin
                    model_error = 1'b0;
                    model_code  = 2'b00;
                end
                if (done) begin
                    check("done_expected", (txn_issued > done_count) ? 1 : 0, 1);
                    done_count++;
                    t_done = $time;
                    code = expected_code(exp_mode, exp_frame);
                    model_code  = code;
                    model_error = (code != 2'b00);
                    if (code == 2'b00) model_data = exp_frame;
                    check("done_busy", busy, 1);
                    if (exp_mode == MODE_FRAME) check_range("done_latency_ns", $time - last_fall, 0, 2250);
                end
                check("data_out", data_out, model_data);
                check("error", error, model_error);
                check("error_code", error_code, model_code);
            end
        end
    endtask

    task automatic wait_pin(input logic v, input int max_us, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_us * 10; i++) begin
            if (dht_io === v) begin
                ok = 1'b1;
                break;
            end
            #100;
        end
    endtask

    task automatic wait_done(input int target, input int max_us, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_us * 10; i++) begin
            if (done_count >= target) begin
                ok = 1'b1;
                break;
            end
            #100;
        end
    endtask

    task automatic wait_idle(input int max_us, output time t, output bit ok);
        ok = 1'b0;
        t = 0;
        for (int i = 0; i < max_us * 10; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                t = $time;
                break;
            end
            #100;
        end
        check("idle_reached", ok, 1);
    endtask

    task automatic sensor_frame(input logic [39:0] frame, input int nbits);
        int d;
        d = $urandom_range(20, 40);
        #(d * 1000);
        sensor_low = 1'b1;
        #80000;
        sensor_low = 1'b0;
        #80000;
        for (int b = 0; b < nbits; b++) begin
            sensor_low = 1'b1;
            d = $urandom_range(8, 15);
            #(d * 1000);
            sensor_low = 1'b0;
            d = frame[39 - b] ? $urandom_range(50, 75) : $urandom_range(5, 30);
            #(d * 1000);
        end
        if (nbits == 40) begin
            last_fall = $time;
            sensor_low = 1'b1;
            #50000;
            sensor_low = 1'b0;
        end
    endtask

    task automatic run_txn(input int mode, input logic [39:0] frame, input int nbits,
                           output time t_rel, output time t_dn);
        bit  ok;
        time t_low;
        int  target;
        exp_mode  = mode;
        exp_frame = frame;
        txn_issued++;
        target = txn_issued;
        t_rel = 0;
        t_dn  = 0;
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_pin(1'b0, 20, ok);
        check("host_start_low", ok, 1);
        if (!ok) return;
        t_low = $time;
        wait_pin(1'b1, 3000, ok);
        check("host_release", ok, 1);
        t_rel = $time;
        check_range("host_low_ns", t_rel - t_low, 1099000, 1101000);
        if (mode != MODE_NONE) sensor_frame(frame, nbits);
        wait_done(target, 6000, ok);
        check("done_seen", ok, 1);
        t_dn = t_done;
    endtask

    initial begin
        time         t_rel;
        time         t_dn;
        time         t_idle;
        time         t1;
        bit          ok;
        int          target;
        int          sum;
        logic [39:0] frame;
        logic [7:0]  b1, b2, b3, b4, cs;

        fork
            compare_loop();
        join_none

        repeat (4) @(posedge clock);
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_error_code", error_code, 0);
        check("rst_line_released", dht_io, 1);
        @(negedge clock);
        reset = 1'b0;

        // Good DHT22 frame, then a start during cooldown that must be dropped.
        run_txn(MODE_FRAME, 40'h028C015FEE, 40, t_rel, t_dn);
        check("good_data_out", data_out, 40'h028C015FEE);
        check("good_code", error_code, 2'b00);
        #10000;
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_idle(1500, t_idle, ok);
        #20000;
        check("cooldown_start_dropped", busy, 0);
        check("no_extra_done", done_count, 1);

        // Checksum mismatch keeps the previous frame.
        run_txn(MODE_FRAME, 40'h028C015FEF, 40, t_rel, t_dn);
        check("bad_cs_code", error_code, 2'b11);
        check("bad_cs_error", error, 1);
        check("bad_cs_data_out", data_out, 40'h028C015FEE);
        wait_idle(1500, t_idle, ok);

        // No sensor: abort ~TIMEOUT_US after release, busy held through cooldown.
        run_txn(MODE_NONE, 40'h0, 0, t_rel, t_dn);
        check("no_resp_code", error_code, 2'b01);
        check_range("no_resp_timeout_ns", t_dn - t_rel, 99000, 103000);
        wait_idle(1500, t_idle, ok);
        check_range("cooldown_ns", t_idle - t_dn, 999000, 1003000);

        // Sensor goes silent after bit 20 with the line high.
        run_txn(MODE_ABORT, 40'h1122334455, 21, t_rel, t_dn);
        check("abort_code", error_code, 2'b10);
        check("abort_data_out", data_out, 40'h028C015FEE);
        wait_idle(1500, t_idle, ok);

        // Start held high: one transaction per cooldown period.
        exp_mode = MODE_NONE;
        txn_issued += 2;
        target = txn_issued;
        @(posedge clock);
        #1 start = 1'b1;
        wait_done(target - 1, 3000, ok);
        check("held_first_done", ok, 1);
        t1 = t_done;
        wait_done(target, 3000, ok);
        check("held_second_done", ok, 1);
        start = 1'b0;
        check_range("held_period_ns", t_done - t1, 2198000, 2206000);
        wait_idle(1500, t_idle, ok);
        #20000;
        check("held_txn_count", done_count, target);

        // Reset in the middle of the host start-low phase.
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_pin(1'b0, 20, ok);
        check("rst_test_start_low", ok, 1);
        #500137;
        reset = 1'b1;
        #1;
        check("rst_async_release", dht_io, 1);
        check("rst_async_busy", busy, 0);
        check("rst_async_data_out", data_out, 0);
        check("rst_async_error", error, 0);
        check("rst_async_code", error_code, 0);
        #2000;
        @(negedge clock);
        reset = 1'b0;

        // Random frames; the first is always valid to prove recovery after reset.
        for (int i = 0; i < 3; i++) begin
            b1 = 8'($urandom_range(0, 255));
            b2 = 8'($urandom_range(0, 255));
            b3 = 8'($urandom_range(0, 255));
            b4 = 8'($urandom_range(0, 255));
            sum = (int'(b1) + int'(b2) + int'(b3) + int'(b4)) % 256;
            if (i != 0 && $urandom_range(0, 1) == 1) sum = (sum + $urandom_range(1, 255)) % 256;
            cs = 8'(sum);
            frame = {b1, b2, b3, b4, cs};
            run_txn(MODE_FRAME, frame, 40, t_rel, t_dn);
            wait_idle(1500, t_idle, ok);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
